if_fetch_unit: RTL and testbench

- Fetch stage that produces the instruction word and PC+1 consumed by the IF/ID pipeline register (RD and PCp1F).
- Owns the word-addressed PC and issues requests to instruction memory through a req/ready handshake that tolerates wait states.
- Holds one fetched instruction while the pipeline is stalled.
- Takes branch and jump redirects from ID and squashes any in-flight wrong-path fetch.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit_buffer.sv | 45 ++++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch unit:
//   fetch_state_e    : fetch FSM states (S_REQ, S_WAIT, S_DROP)
//   NOP              : instruction word presented when no instruction is held
//   DEFAULT_RESET_PC : default word address loaded into the PC on reset
// ----------------------------------------------------------------------------
package if_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // issuing (or ready to issue) a request at pc
      S_WAIT = 2'd1,   // request outstanding, address held until ready
      S_DROP = 2'd2    // wrong-path request outstanding, response discarded
   } fetch_state_e;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response handshake used by the fetch unit.
//   req   : request valid (fetch unit -> memory)
//   addr  : word address of the request (fetch unit -> memory)
//   ready : request accepted, rdata valid this cycle (memory -> fetch unit)
//   rdata : instruction word (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
// ----------------------------------------------------------------------------
interface if_fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_fetch_unit_buffer.sv
// ----------------------------------------------------------------------------
// if_fetch_buffer
// Single-entry holding register between instruction memory and IF/ID.
//   clk, rst  : clock, synchronous active-high reset (clears valid only)
//   load      : capture instr_d/pc1_d this edge
//   flush     : invalidate this edge; wins over load and consume
//   consume   : downstream takes the entry this edge
//   instr_d   : incoming instruction word
//   pc1_d     : PC+1 belonging to instr_d
//   valid     : entry holds an instruction
//   instr     : held instruction word
//   pc1       : held PC+1
// ----------------------------------------------------------------------------
module if_fetch_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic              consume,
   input  logic [DATA_W-1:0] instr_d,
   input  logic [ADDR_W-1:0] pc1_d,
   output logic              valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc1
);

   always_ff @(posedge clk) begin
      if (rst)          valid <= 1'b0;
      else if (flush)   valid <= 1'b0;
      else if (load)    valid <= 1'b1;
      else if (consume) valid <= 1'b0;
   end

   // Payload is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (load && !flush) begin
         instr <= instr_d;
         pc1   <= pc1_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Fetch stage: owns the word-addressed PC, requests instructions through a
// req/ready handshake tolerating wait states, holds one instruction while the
// pipeline stalls, and applies branch/jump redirects from ID (branch wins).
//   clk, rst          : clock, synchronous active-high reset
//   stall_i           : pipeline stall (inverse enables IF/ID)
//   branch_taken_i    : ID branch resolved taken, target branch_target_i
//   jump_i            : ID jump, target jump_target_i
//   imem              : instruction-memory handshake (master side)
//   instr_o           : instruction to IF/ID, NOP when not valid
//   pc_plus1_o        : PC+1 of instr_o, 0 when not valid
//   instr_valid_o     : holding buffer has an instruction
//   pc_o              : next fetch PC (debug)
// Optional (IF_PERF_CNT_EN defined):
//   fetch_count_o     : accepted, non-discarded fetches
//   wait_cycles_o     : cycles spent in S_WAIT or S_DROP
// ----------------------------------------------------------------------------
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               branch_taken_i,
   input  logic [ADDR_W-1:0]  branch_target_i,
   input  logic               jump_i,
   input  logic [ADDR_W-1:0]  jump_target_i,
   if_fetch_unit_if.master    imem,
   output logic [DATA_W-1:0]  instr_o,
   output logic [ADDR_W-1:0]  pc_plus1_o,
   output logic               instr_valid_o,
   output logic [ADDR_W-1:0]  pc_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count_o,
   output logic [31:0]        wait_cycles_o
`endif
);

   fetch_state_e      state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, req_addr;
   logic [ADDR_W-1:0] target, fill_pc1;
   logic              redir, space, req, load;
   logic              buf_valid;
   logic [DATA_W-1:0] buf_instr;
   logic [ADDR_W-1:0] buf_pc1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
         pc    <= RESET_PC;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   // Address of the request currently on the bus; frozen once we leave S_REQ.
   always_ff @(posedge clk) begin
      if (state == S_REQ) req_addr <= pc;
   end

   always_comb begin
      redir    = branch_taken_i | jump_i;
      target   = branch_taken_i ? branch_target_i : jump_target_i;
      space    = !buf_valid || !stall_i;
      state_n  = state;
      pc_n     = pc;
      req      = 1'b0;
      load     = 1'b0;
      fill_pc1 = pc + 1'b1;
      imem.addr = req_addr;
      case (state)
         S_REQ: begin
            req       = space;
            imem.addr = pc;
            if (req && imem.ready) begin
               load = !redir;
               pc_n = pc + 1'b1;
            end else if (req) begin
               state_n = redir ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            req      = 1'b1;
            fill_pc1 = req_addr + 1'b1;
            if (imem.ready) begin
               load    = !redir;
               pc_n    = req_addr + 1'b1;
               state_n = S_REQ;
            end else if (redir) begin
               state_n = S_DROP;
            end
         end
         S_DROP: begin
            // pc already holds the redirect target; just drain the response.
            req = 1'b1;
            if (imem.ready) state_n = S_REQ;
         end
         default: state_n = S_REQ;
      endcase
      if (redir) pc_n = target;
   end

   assign imem.req = req && !rst;

   if_fetch_buffer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .flush   (redir),
      .consume (buf_valid && !stall_i),
      .instr_d (imem.rdata),
      .pc1_d   (fill_pc1),
      .valid   (buf_valid),
      .instr   (buf_instr),
      .pc1     (buf_pc1)
   );

   assign instr_valid_o = buf_valid;
   assign instr_o       = (buf_valid && !rst) ? buf_instr : DATA_W'(NOP);
   assign pc_plus1_o    = (buf_valid && !rst) ? buf_pc1   : '0;
   assign pc_o          = pc;

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_o <= '0;
         wait_cycles_o <= '0;
      end else begin
         if (load)            fetch_count_o <= fetch_count_o + 1'b1;
         if (state != S_REQ)  wait_cycles_o <= wait_cycles_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall, br, jp, rdy;
   logic [31:0] btgt, jtgt;
   logic [31:0] instr, pc1, pc;
   logic        valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fcnt, wcnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) mem ();

   // Memory model: every word holds its own address times four.
   always_comb begin
      mem.ready = rdy;
      mem.rdata = {mem.addr[29:0], 2'b00};
   end

   if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (btgt),
      .jump_i          (jp),
      .jump_target_i   (jtgt),
      .imem            (mem.master),
      .instr_o         (instr),
      .pc_plus1_o      (pc1),
      .instr_valid_o   (valid),
      .pc_o            (pc)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count_o   (fcnt),
      .wait_cycles_o   (wcnt)
`endif
   );

   typedef struct {
      logic        rst, stall, br, jp, rdy;
      logic [31:0] btgt, jtgt;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr, e_pc1, e_pc;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, s, b, j, rd, input logic [31:0] bt, jt,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic evld, input logic [31:0] einstr, epc1, epc);
      vec_t v;
      v.rst = r; v.stall = s; v.br = b; v.jp = j; v.rdy = rd;
      v.btgt = bt; v.jtgt = jt;
      v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evld;
      v.e_instr = einstr; v.e_pc1 = epc1; v.e_pc = epc;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, s, b, j, rd, input logic [31:0] bt, jt);
      rst = r; stall = s; br = b; jp = j; rdy = rd; btgt = bt; jtgt = jt;
   endtask

   initial begin
      bit seen;
      //   rst stl br jp rdy btgt          jtgt          req addr          vld instr         pc1           pc
      add(1, 0, 0, 0, 1, 0,            0,            0, 32'h0,         0, 32'h0,         32'h0,        32'h0);   // reset state
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h0,         0, 32'h0,         32'h0,        32'h0);   // zero-wait stream
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h1,         1, 32'h0,         32'h1,        32'h1);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h2,         1, 32'h4,         32'h2,        32'h2);
      add(0, 1, 0, 0, 1, 0,            0,            0, 32'h3,         1, 32'h8,         32'h3,        32'h3);   // stall x4
      add(0, 1, 0, 0, 1, 0,            0,            0, 32'h3,         1, 32'h8,         32'h3,        32'h3);
      add(0, 1, 0, 0, 1, 0,            0,            0, 32'h3,         1, 32'h8,         32'h3,        32'h3);
      add(0, 1, 0, 0, 1, 0,            0,            0, 32'h3,         1, 32'h8,         32'h3,        32'h3);
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h3,         1, 32'h8,         32'h3,        32'h3);   // wait at 3
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h3,         0, 32'h0,         32'h0,        32'h3);
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h3,         0, 32'h0,         32'h0,        32'h3);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h3,         0, 32'h0,         32'h0,        32'h3);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h4,         1, 32'hC,         32'h4,        32'h4);
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h5,         1, 32'h10,        32'h5,        32'h5);   // 3 wait cycles at 5
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h5,         0, 32'h0,         32'h0,        32'h5);
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h5,         0, 32'h0,         32'h0,        32'h5);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h5,         0, 32'h0,         32'h0,        32'h5);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h6,         1, 32'h14,        32'h6,        32'h6);
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h7,         1, 32'h18,        32'h7,        32'h7);   // wait at 7
      add(0, 0, 1, 0, 0, 32'h40,       0,            1, 32'h7,         0, 32'h0,         32'h0,        32'h7);   // branch in S_WAIT
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h7,         0, 32'h0,         32'h0,        32'h40);  // S_DROP
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h7,         0, 32'h0,         32'h0,        32'h40);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h40,        0, 32'h0,         32'h0,        32'h40);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h41,        1, 32'h100,       32'h41,       32'h41);
      add(0, 0, 1, 1, 1, 32'h10,       32'h20,       1, 32'h42,        1, 32'h104,       32'h42,       32'h42);  // branch+jump+ready
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h10,        0, 32'h0,         32'h0,        32'h10);
      add(1, 0, 0, 0, 0, 0,            0,            0, 32'h10,        0, 32'h0,         32'h0,        32'h10);  // reset in S_WAIT
      add(0, 0, 0, 0, 0, 0,            0,            1, 32'h0,         0, 32'h0,         32'h0,        32'h0);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h0,         0, 32'h0,         32'h0,        32'h0);
      add(0, 0, 0, 1, 0, 0,            32'h30,       1, 32'h1,         1, 32'h0,         32'h1,        32'h1);   // jump, no ready
      add(0, 0, 0, 1, 0, 0,            32'h50,       1, 32'h1,         0, 32'h0,         32'h0,        32'h30);  // retarget in S_DROP
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h1,         0, 32'h0,         32'h0,        32'h50);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h50,        0, 32'h0,         32'h0,        32'h50);
      add(0, 1, 1, 0, 1, 32'h60,       0,            0, 32'h51,        1, 32'h140,       32'h51,       32'h51);  // redirect under stall
      add(0, 1, 0, 0, 1, 0,            0,            1, 32'h60,        0, 32'h0,         32'h0,        32'h60);
      add(0, 1, 0, 0, 1, 0,            0,            0, 32'h61,        1, 32'h180,       32'h61,       32'h61);
      add(0, 0, 0, 1, 1, 0,            32'hFFFFFFFF, 1, 32'h61,        1, 32'h180,       32'h61,       32'h61);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'hFFFFFFFF,  0, 32'h0,         32'h0,        32'hFFFFFFFF);
      add(0, 0, 0, 0, 1, 0,            0,            1, 32'h0,         1, 32'hFFFFFFFC,  32'h0,        32'h0);   // pc wrap

      drive(1, 0, 0, 0, 1, 0, 0);
      @(posedge clk);
      foreach (vq[i]) begin
         #1;
         drive(vq[i].rst, vq[i].stall, vq[i].br, vq[i].jp, vq[i].rdy, vq[i].btgt, vq[i].jtgt);
         @(negedge clk);
         chk("req",   i, 32'(mem.req), 32'(vq[i].e_req));
         if (vq[i].e_req) chk("addr", i, mem.addr, vq[i].e_addr);
         chk("valid", i, 32'(valid),   32'(vq[i].e_valid));
         chk("instr", i, instr,        vq[i].e_instr);
         chk("pc1",   i, pc1,          vq[i].e_pc1);
         chk("pc",    i, pc,           vq[i].e_pc);
         @(posedge clk);
      end

      // Redirect while a wait-state request is outstanding: the stale word
      // for address 0 must never appear, and the first valid word is 0x40's.
      #1 drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 drive(0, 0, 1, 0, 0, 32'h40, 0);
      @(negedge clk);
      chk("seq_wait_addr", 100, mem.addr, 32'h0);
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("seq_drop_req",   101, 32'(mem.req), 32'h1);
      chk("seq_drop_addr",  101, mem.addr, 32'h0);
      chk("seq_drop_valid", 101, 32'(valid), 32'h0);
      @(posedge clk);
      #1 rdy = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1'b1;
            chk("seq_first_instr", 102, instr, 32'h100);
            chk("seq_first_pc1",   102, pc1,   32'h41);
         end
         @(posedge clk);
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL seq_timeout actual=no_valid required=valid_within_10_cycles");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
